id_ex_ctrl_seg: RTL and testbench
=================================

# id_ex_ctrl_seg

ID/EX control segment register with integrated load-use and control-flow hazard handling. Sits directly downstream of the instruction decoder: captures the decoded ID-stage control bundle plus register indices each cycle and presents them to the EX stage. Inserts bubbles on load-use hazards, EX-resolved branches/JALR and ID-stage JAL, and drives the fetch/decode stall and flush lines. Keeps a saturating bubble counter for performance debug.

## Interface
Parameters:
- CNT_W, 16, width of bubble counter

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- hold  in  1  external memory stall; freezes this stage
- JalD  in  1  decoder JAL flag
- JalrD  in  1  decoder JALR flag
- RegWriteD  in  3  register write mode; 3'b000 = NOREGWRITE
- MemToRegD  in  1  load result to register
- MemWriteD  in  4  byte write enables
- LoadNpcD  in  1  NextPC to result
- RegReadD  in  2  [1] rs1 used, [0] rs2 used
- BranchTypeD  in  3  branch type; 3'b000 = NOBRANCH
- AluContrlD  in  4  ALU function
- AluSrc2D  in  2  ALU operand 2 select
- AluSrc1D  in  1  ALU operand 1 select
- Rs1D, Rs2D, RdD  in  5 each  register indices from instr[19:15], [24:20], [11:7]
- BranchE  in  1  branch taken, resolved in EX
- JalrE, RegWriteE, MemToRegE, MemWriteE, LoadNpcE, RegReadE, BranchTypeE, AluContrlE, AluSrc2E, AluSrc1E, Rs1E, Rs2E, RdE  out  widths as D counterparts  registered bundle
- StallF  out  1  hold PC
- StallD  out  1  hold IF/ID register
- FlushD  out  1  clear IF/ID register
- BubbleCnt  out  CNT_W  bubbles inserted since reset, saturating

## Operation
- Bubble = all E outputs zero (NOREGWRITE, NOBRANCH, MemWriteE=0, RdE=0).
- loaduse = MemToRegE & (RegWriteE!=0) & (RdE!=0) & ((RegReadD[1] & Rs1D==RdE) | (RegReadD[0] & Rs2D==RdE)).
- redirect = BranchE | JalrE.
- Priority per cycle, highest first:
  - hold=1: all E registers and BubbleCnt hold; StallF=StallD=1, FlushD=0.
  - redirect=1: E loads bubble; FlushD=1; StallF=StallD=0 (loaduse ignored; wrong-path instruction discarded).
  - loaduse=1: E loads bubble; StallF=StallD=1; FlushD=0.
  - JalD=1: E loads D bundle normally; FlushD=1; StallF=StallD=0.
  - else: E loads D bundle; all hazard outputs 0.
- BubbleCnt increments by 1 on each edge where a bubble is loaded due to redirect or loaduse; holds at all-ones; JalD flush does not count.
- JalD itself is not registered to EX (JAL resolves in ID); JalrE is.
- Rd=0 never triggers loaduse.

## Timing
- E outputs, BubbleCnt: registered, update on rising clk; 1-cycle latency D -> E.
- StallF, StallD, FlushD: combinational from current E registers, D inputs, BranchE, hold; valid same cycle.
- Reset (rst_n=0, any time, including mid-stall): all E outputs and BubbleCnt clear to 0 immediately; hazard outputs then 0 unless hold=1.
- Load-use stall lasts exactly one cycle: bubble clears MemToRegE next cycle.
- hold asserted during loaduse: stall persists, no bubble, no count, until hold drops.
- BranchE and loaduse same cycle: flush wins, counter +1 only.

## Test plan
- Reset: drive D bundle nonzero, rst_n=0 mid-cycle -> all E outputs 0, BubbleCnt=0 immediately; release -> next edge RegWriteE=D value, AluContrlE=D value.
- Load-use: E holds load (MemToRegE=1, RegWriteE=3'b001, RdE=5), D has RegReadD=2'b10, Rs1D=5 -> StallF=StallD=1, next edge E bubble, BubbleCnt=1; following cycle D bundle passes.
- No false hazard: same as above but RdE=0, or RegReadD=2'b01 with Rs2D=6 -> no stall, BubbleCnt unchanged.
- Redirect vs load-use: BranchE=1 with loaduse true -> FlushD=1, StallF=StallD=0, E bubble, BubbleCnt +1.
- JAL: JalD=1, no other hazard -> FlushD=1, E loads D bundle (LoadNpcE=1), BubbleCnt unchanged.
- Hold and saturation: hold=1 for 3 cycles -> E unchanged, StallF=StallD=1; with CNT_W=4 force 20 load-use bubbles -> BubbleCnt=4'hF.

Source files
------------

// File: rtl/id_ex_ctrl_seg.sv
// ---------------------------------------------------------------------------
// id_ex_ctrl_seg
//
// ID/EX control segment register. Captures the decoded ID control bundle and
// register indices every cycle and presents them to EX. Bubbles are inserted
// for load-use hazards and for EX-resolved redirects (taken branch or JALR).
// JAL in ID is not a bubble: the JAL itself proceeds into EX and only the
// fetched-behind instruction is flushed. A saturating counter records how
// many bubbles were inserted.
//
// Parameters:
//   CNT_W        width of BubbleCnt
//
// Ports:
//   clk, rst_n   core clock (rising edge), async active-low reset
//   hold         external memory stall, freezes the whole stage
//   *D           decoded ID-stage bundle and register indices
//   BranchE      branch taken, resolved in EX
//   *E           registered bundle presented to EX (JalD is not carried)
//   StallF       hold PC
//   StallD       hold IF/ID register
//   FlushD       clear IF/ID register
//   BubbleCnt    bubbles inserted since reset, saturating
// ---------------------------------------------------------------------------
module id_ex_ctrl_seg #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold,
    input  logic             JalD,
    input  logic             JalrD,
    input  logic [2:0]       RegWriteD,
    input  logic             MemToRegD,
    input  logic [3:0]       MemWriteD,
    input  logic             LoadNpcD,
    input  logic [1:0]       RegReadD,
    input  logic [2:0]       BranchTypeD,
    input  logic [3:0]       AluContrlD,
    input  logic [1:0]       AluSrc2D,
    input  logic             AluSrc1D,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RdD,
    input  logic             BranchE,
    output logic             JalrE,
    output logic [2:0]       RegWriteE,
    output logic             MemToRegE,
    output logic [3:0]       MemWriteE,
    output logic             LoadNpcE,
    output logic [1:0]       RegReadE,
    output logic [2:0]       BranchTypeE,
    output logic [3:0]       AluContrlE,
    output logic [1:0]       AluSrc2E,
    output logic             AluSrc1E,
    output logic [4:0]       Rs1E,
    output logic [4:0]       Rs2E,
    output logic [4:0]       RdE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic [CNT_W-1:0] BubbleCnt
);

    logic loaduse;
    logic redirect;
    logic bubble;

    // A load in EX whose destination is read by the instruction in ID.
    // x0 is never a real dependency.
    assign loaduse = MemToRegE & (RegWriteE != 3'b000) & (RdE != 5'd0) &
                     ((RegReadD[1] & (Rs1D == RdE)) |
                      (RegReadD[0] & (Rs2D == RdE)));

    assign redirect = BranchE | JalrE;

    // Redirect outranks load-use: the ID instruction is on the wrong path,
    // so there is nothing worth stalling for.
    assign bubble = ~hold & (redirect | loaduse);

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        FlushD = 1'b0;
        if (hold) begin
            StallF = 1'b1;
            StallD = 1'b1;
        end else if (redirect) begin
            FlushD = 1'b1;
        end else if (loaduse) begin
            StallF = 1'b1;
            StallD = 1'b1;
        end else if (JalD) begin
            FlushD = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            JalrE       <= 1'b0;
            RegWriteE   <= 3'b000;
            MemToRegE   <= 1'b0;
            MemWriteE   <= 4'b0000;
            LoadNpcE    <= 1'b0;
            RegReadE    <= 2'b00;
            BranchTypeE <= 3'b000;
            AluContrlE  <= 4'b0000;
            AluSrc2E    <= 2'b00;
            AluSrc1E    <= 1'b0;
            Rs1E        <= 5'd0;
            Rs2E        <= 5'd0;
            RdE         <= 5'd0;
            BubbleCnt   <= '0;
        end else if (!hold) begin
            if (bubble) begin
                JalrE       <= 1'b0;
                RegWriteE   <= 3'b000;
                MemToRegE   <= 1'b0;
                MemWriteE   <= 4'b0000;
                LoadNpcE    <= 1'b0;
                RegReadE    <= 2'b00;
                BranchTypeE <= 3'b000;
                AluContrlE  <= 4'b0000;
                AluSrc2E    <= 2'b00;
                AluSrc1E    <= 1'b0;
                Rs1E        <= 5'd0;
                Rs2E        <= 5'd0;
                RdE         <= 5'd0;
                if (BubbleCnt != {CNT_W{1'b1}}) begin
                    BubbleCnt <= BubbleCnt + 1'b1;
                end
            end else begin
                JalrE       <= JalrD;
                RegWriteE   <= RegWriteD;
                MemToRegE   <= MemToRegD;
                MemWriteE   <= MemWriteD;
                LoadNpcE    <= LoadNpcD;
                RegReadE    <= RegReadD;
                BranchTypeE <= BranchTypeD;
                AluContrlE  <= AluContrlD;
                AluSrc2E    <= AluSrc2D;
                AluSrc1E    <= AluSrc1D;
                Rs1E        <= Rs1D;
                Rs2E        <= Rs2D;
                RdE         <= RdD;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_ctrl_seg.sv
// ---------------------------------------------------------------------------
// tb_id_ex_ctrl_seg
//
// Bench for id_ex_ctrl_seg with a 4-bit bubble counter so saturation is
// reachable. A reference model holds the EX bundle as a packed record and
// applies the hazard priority rules directly; directed sequences cover the
// named scenarios, then a randomized run is checked against the same model.
// ---------------------------------------------------------------------------
module tb_id_ex_ctrl_seg;

    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    typedef struct packed {
        logic       jalr;
        logic [2:0] regwrite;
        logic       memtoreg;
        logic [3:0] memwrite;
        logic       loadnpc;
        logic [1:0] regread;
        logic [2:0] btype;
        logic [3:0] alu;
        logic [1:0] src2;
        logic       src1;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } ebundle_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          hold;
    logic          JalD, JalrD;
    logic [2:0]    RegWriteD;
    logic          MemToRegD;
    logic [3:0]    MemWriteD;
    logic          LoadNpcD;
    logic [1:0]    RegReadD;
    logic [2:0]    BranchTypeD;
    logic [3:0]    AluContrlD;
    logic [1:0]    AluSrc2D;
    logic          AluSrc1D;
    logic [4:0]    Rs1D, Rs2D, RdD;
    logic          BranchE;
    logic          JalrE;
    logic [2:0]    RegWriteE;
    logic          MemToRegE;
    logic [3:0]    MemWriteE;
    logic          LoadNpcE;
    logic [1:0]    RegReadE;
    logic [2:0]    BranchTypeE;
    logic [3:0]    AluContrlE;
    logic [1:0]    AluSrc2E;
    logic          AluSrc1E;
    logic [4:0]    Rs1E, Rs2E, RdE;
    logic          StallF, StallD, FlushD;
    logic [CW-1:0] BubbleCnt;

    ebundle_t e_act;
    assign e_act = {JalrE, RegWriteE, MemToRegE, MemWriteE, LoadNpcE, RegReadE,
                    BranchTypeE, AluContrlE, AluSrc2E, AluSrc1E, Rs1E, Rs2E, RdE};

    ebundle_t m_e;
    int       m_cnt;
    int       n_checks = 0;
    int       n_errors = 0;

    always #5 clk = ~clk;

    id_ex_ctrl_seg #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .hold(hold),
        .JalD(JalD), .JalrD(JalrD), .RegWriteD(RegWriteD), .MemToRegD(MemToRegD),
        .MemWriteD(MemWriteD), .LoadNpcD(LoadNpcD), .RegReadD(RegReadD),
        .BranchTypeD(BranchTypeD), .AluContrlD(AluContrlD), .AluSrc2D(AluSrc2D),
        .AluSrc1D(AluSrc1D), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .BranchE(BranchE),
        .JalrE(JalrE), .RegWriteE(RegWriteE), .MemToRegE(MemToRegE),
        .MemWriteE(MemWriteE), .LoadNpcE(LoadNpcE), .RegReadE(RegReadE),
        .BranchTypeE(BranchTypeE), .AluContrlE(AluContrlE), .AluSrc2E(AluSrc2E),
        .AluSrc1E(AluSrc1E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .BubbleCnt(BubbleCnt)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic ebundle_t d_bundle();
        return {JalrD, RegWriteD, MemToRegD, MemWriteD, LoadNpcD, RegReadD,
                BranchTypeD, AluContrlD, AluSrc2D, AluSrc1D, Rs1D, Rs2D, RdD};
    endfunction

    // Does the instruction in ID read the destination of a load sitting in EX?
    function automatic bit model_loaduse();
        bit reads_it;
        if (!m_e.memtoreg || m_e.regwrite == 3'b000 || m_e.rd == 5'd0) return 1'b0;
        reads_it = (RegReadD[1] && Rs1D == m_e.rd) || (RegReadD[0] && Rs2D == m_e.rd);
        return reads_it;
    endfunction

    task automatic clear_d();
        hold = 0; JalD = 0; JalrD = 0; RegWriteD = 0; MemToRegD = 0; MemWriteD = 0;
        LoadNpcD = 0; RegReadD = 0; BranchTypeD = 0; AluContrlD = 0; AluSrc2D = 0;
        AluSrc1D = 0; Rs1D = 0; Rs2D = 0; RdD = 0; BranchE = 0;
    endtask

    // Small register range and frequent loads so hazards happen often.
    task automatic rand_d();
        hold        = ($urandom_range(0, 7) == 0);
        JalD        = ($urandom_range(0, 7) == 0);
        JalrD       = ($urandom_range(0, 7) == 0);
        BranchE     = ($urandom_range(0, 7) == 0);
        RegWriteD   = 3'($urandom_range(0, 7));
        MemToRegD   = 1'($urandom_range(0, 1));
        MemWriteD   = 4'($urandom);
        LoadNpcD    = 1'($urandom);
        RegReadD    = 2'($urandom);
        BranchTypeD = 3'($urandom);
        AluContrlD  = 4'($urandom);
        AluSrc2D    = 2'($urandom);
        AluSrc1D    = 1'($urandom);
        Rs1D        = 5'($urandom_range(0, 3));
        Rs2D        = 5'($urandom_range(0, 3));
        RdD         = 5'($urandom_range(0, 3));
    endtask

    // One clock: check hazard lines mid-cycle, advance the model at the edge,
    // then check the registered bundle and counter just after the edge.
    task automatic cycle();
        bit       exp_sf, exp_fd, do_bubble, lu, redir;
        ebundle_t d;
        #1;
        lu    = model_loaduse();
        redir = BranchE || m_e.jalr;
        exp_sf = 0; exp_fd = 0; do_bubble = 0;
        if (hold)           exp_sf = 1;
        else if (redir)     begin exp_fd = 1; do_bubble = 1; end
        else if (lu)        begin exp_sf = 1; do_bubble = 1; end
        else if (JalD)      exp_fd = 1;
        chk("StallF", 64'(StallF), 64'(exp_sf));
        chk("StallD", 64'(StallD), 64'(exp_sf));
        chk("FlushD", 64'(FlushD), 64'(exp_fd));
        d = d_bundle();
        @(posedge clk);
        if (!hold) begin
            if (do_bubble) begin
                m_e = '0;
                if (m_cnt < MAXC) m_cnt++;
            end else begin
                m_e = d;
            end
        end
        #1;
        chk("Ebundle", 64'(e_act), 64'(m_e));
        chk("BubbleCnt", 64'(BubbleCnt), 64'(m_cnt));
    endtask

    task automatic drive_load(input logic [4:0] rd);
        clear_d();
        MemToRegD = 1; RegWriteD = 3'b001; RdD = rd; AluContrlD = 4'h3;
    endtask

    task automatic do_reset_mid_cycle();
        clear_d();
        RegWriteD = 3'b101; AluContrlD = 4'hA; MemWriteD = 4'hF; RdD = 5'd7;
        #2;
        rst_n = 0;
        #1;
        m_e = '0; m_cnt = 0;
        chk("rst_Ebundle", 64'(e_act), 64'(0));
        chk("rst_BubbleCnt", 64'(BubbleCnt), 64'(0));
        chk("rst_FlushD", 64'(FlushD), 64'(0));
        rst_n = 1;
        cycle();
        chk("rst_rel_RegWriteE", 64'(RegWriteE), 64'(3'b101));
        chk("rst_rel_AluContrlE", 64'(AluContrlE), 64'(4'hA));
    endtask

    initial begin
        ebundle_t snap;
        int cnt_before;
        rst_n = 0;
        clear_d();
        m_e = '0; m_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        chk("init_Ebundle", 64'(e_act), 64'(0));

        // reset mid-cycle while a nonzero bundle is being presented
        rand_d(); hold = 0;
        repeat (3) begin rand_d(); hold = 0; cycle(); end
        do_reset_mid_cycle();

        // load-use stall, one bubble, then the dependent instruction passes
        drive_load(5'd5); cycle();
        clear_d(); RegReadD = 2'b10; Rs1D = 5'd5; AluContrlD = 4'h6;
        cycle();
        chk("lu_cnt", 64'(BubbleCnt), 64'(1));
        chk("lu_bubble_rd", 64'(RdE), 64'(0));
        cycle();
        chk("lu_pass_rs1", 64'(Rs1E), 64'(5));

        // no false hazard: destination x0
        drive_load(5'd0); cycle();
        clear_d(); RegReadD = 2'b10; Rs1D = 5'd0; cycle();
        chk("nf_rd0_cnt", 64'(BubbleCnt), 64'(1));
        // no false hazard: rs2 used but differs, rs1 matches but unused
        drive_load(5'd5); cycle();
        clear_d(); RegReadD = 2'b01; Rs1D = 5'd5; Rs2D = 5'd6; cycle();
        chk("nf_rs2_cnt", 64'(BubbleCnt), 64'(1));

        // redirect beats load-use
        drive_load(5'd5); cycle();
        clear_d(); RegReadD = 2'b10; Rs1D = 5'd5; BranchE = 1;
        #1;
        chk("rd_FlushD", 64'(FlushD), 64'(1));
        chk("rd_StallF", 64'(StallF), 64'(0));
        cycle();
        chk("rd_cnt", 64'(BubbleCnt), 64'(2));

        // JAL: flush, bundle passes, no count
        clear_d(); JalD = 1; LoadNpcD = 1; RegWriteD = 3'b001; RdD = 5'd1;
        cycle();
        chk("jal_LoadNpcE", 64'(LoadNpcE), 64'(1));
        chk("jal_cnt", 64'(BubbleCnt), 64'(2));

        // hold for three cycles freezes E even with a load-use pending
        drive_load(5'd9); cycle();
        snap = e_act;
        clear_d(); RegReadD = 2'b11; Rs2D = 5'd9; hold = 1;
        repeat (3) cycle();
        chk("hold_E", 64'(e_act), 64'(snap));
        chk("hold_cnt", 64'(BubbleCnt), 64'(2));
        hold = 0; cycle();
        chk("hold_release_cnt", 64'(BubbleCnt), 64'(3));

        // randomized run
        for (int i = 0; i < 2000; i++) begin
            rand_d();
            cycle();
        end

        // saturation: fresh reset, then 20 forced load-use bubbles
        do_reset_mid_cycle();
        for (int i = 0; i < 20; i++) begin
            drive_load(5'd4); cycle();
            clear_d(); RegReadD = 2'b01; Rs2D = 5'd4; cycle();
        end
        chk("sat_cnt", 64'(BubbleCnt), 64'(4'hF));
        cnt_before = m_cnt;
        chk("sat_model", 64'(cnt_before), 64'(MAXC));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
